// File: rtl/program_loader_if.sv
// Nibble-stream handshake plus program-memory write port of the program loader.
// The loader uses the slave view; the nibble source / memory model uses the master view.
interface program_loader_if #(
  parameter int ADDR_W = 12
) ();
  logic              nib_valid;
  logic [3:0]        nib;
  logic              nib_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;

  modport master (
    output nib_valid, nib,
    input  nib_ready, mem_we, mem_addr, mem_data
  );

  modport slave (
    input  nib_valid, nib,
    output nib_ready, mem_we, mem_addr, mem_data
  );
endinterface

// File: rtl/program_loader.sv
// Packs {instruction, operand} nibble pairs into bytes written at auto-incrementing addresses.
// Optional feature: define LOADER_CHECKSUM_EN to add the 8-bit running checksum output.
module program_loader #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] length,
  program_loader_if.slave   bus,
  output logic              busy,
`ifdef LOADER_CHECKSUM_EN
  output logic [7:0]        checksum,
`endif
  output logic              done
);

  typedef enum logic [2:0] {IDLE, HI, LO, WRITE, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_cnt;
  logic [ADDR_W-1:0] remaining;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [7:0]        mem_data_q;
  logic [3:0]        hi_nib;
  logic              nib_ready_c, mem_we_c, busy_c, done_c;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt   = state;
    nib_ready_c = 1'b0;
    mem_we_c    = 1'b0;
    busy_c      = 1'b0;
    done_c      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = (length == '0) ? DONE : HI;
      end
      HI: begin
        nib_ready_c = 1'b1;
        busy_c      = 1'b1;
        if (bus.nib_valid) state_nxt = LO;
      end
      LO: begin
        nib_ready_c = 1'b1;
        busy_c      = 1'b1;
        if (bus.nib_valid) state_nxt = WRITE;
      end
      WRITE: begin
        mem_we_c  = 1'b1;
        busy_c    = 1'b1;
        state_nxt = (remaining == ADDR_W'(1)) ? DONE : HI;
      end
      DONE: begin
        done_c    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Write address/data are captured on low-nibble acceptance and then held,
  // so they stay stable through and after the WRITE cycle while the counter moves on.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_cnt   <= '0;
      remaining  <= '0;
      hi_nib     <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
`ifdef LOADER_CHECKSUM_EN
      checksum   <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            addr_cnt  <= start_addr;
            remaining <= length;
`ifdef LOADER_CHECKSUM_EN
            checksum  <= '0;
`endif
          end
        end
        HI: begin
          if (bus.nib_valid) hi_nib <= bus.nib;
        end
        LO: begin
          if (bus.nib_valid) begin
            mem_addr_q <= addr_cnt;
            mem_data_q <= {hi_nib, bus.nib};
          end
        end
        WRITE: begin
          addr_cnt  <= addr_cnt + ADDR_W'(1);
          remaining <= remaining - ADDR_W'(1);
`ifdef LOADER_CHECKSUM_EN
          checksum  <= checksum + mem_data_q;
`endif
        end
        default: ;
      endcase
    end
  end

  assign bus.nib_ready = nib_ready_c;
  assign bus.mem_we    = mem_we_c;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_data  = mem_data_q;
  assign busy          = busy_c;
  assign done          = done_c;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: the driver pushes expected writes/done events
// derived from the load description; a negedge monitor pops and compares.
module tb_program_loader;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          reset, start, busy, done;
  logic [AW-1:0] start_addr, length;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]    checksum;
`endif

  program_loader_if #(.ADDR_W(AW)) bus ();

  program_loader #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .start_addr (start_addr),
    .length     (length),
    .bus        (bus),
    .busy       (busy),
`ifdef LOADER_CHECKSUM_EN
    .checksum   (checksum),
`endif
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  typedef struct {
    int         cyc;   // -1 when the exact cycle is not predicted
    logic [7:0] csum;
  } done_t;

  wr_t   wq[$];
  done_t dq[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  bit    mon_en = 1'b0;

  logic [7:0] lb[16];
  int         gh[16];
  int         gl[16];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Monitor: compares every write and every done pulse against the queues.
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (bus.mem_we) begin
        check("ready_low_in_write", 32'(bus.nib_ready), 32'd0);
        if (wq.size() == 0) fail("unexpected_write");
        else begin
          wr_t w;
          w = wq.pop_front();
          check("wr_addr", 32'(bus.mem_addr), 32'(w.addr));
          check("wr_data", 32'(bus.mem_data), 32'(w.data));
        end
      end
      if (done) begin
        check("busy_low_at_done", 32'(busy), 32'd0);
        if (dq.size() == 0) fail("unexpected_done");
        else begin
          done_t d;
          d = dq.pop_front();
          check("writes_before_done", 32'(wq.size()), 32'd0);
          if (d.cyc >= 0) check("done_cycle", 32'(cyc), 32'(d.cyc));
`ifdef LOADER_CHECKSUM_EN
          check("checksum", 32'(checksum), 32'(d.csum));
`endif
        end
      end
    end
  end

  // Called on a negedge; returns on the negedge after the nibble transferred.
  task automatic send_nib(input logic [3:0] n);
    int guard = 0;
    bus.nib_valid = 1'b1;
    bus.nib       = n;
    while (bus.nib_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) fail("nib_accept_timeout");
    @(negedge clk);
    bus.nib_valid = 1'b0;
    bus.nib       = 4'($urandom);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_nib_ready"}, 32'(bus.nib_ready), 32'd0);
    check({tag, "_mem_we"},    32'(bus.mem_we),    32'd0);
    check({tag, "_mem_addr"},  32'(bus.mem_addr),  32'd0);
    check({tag, "_mem_data"},  32'(bus.mem_data),  32'd0);
    check({tag, "_busy"},      32'(busy),          32'd0);
    check({tag, "_done"},      32'(done),          32'd0);
`ifdef LOADER_CHECKSUM_EN
    check({tag, "_checksum"},  32'(checksum),      32'd0);
`endif
  endtask

  // Model: byte i lands at (sa + i) mod 2^AW; checksum is the byte sum mod 256.
  // exp_off: cycles from the start edge to the done cycle, or -1 for "don't predict".
  task automatic do_load(input logic [AW-1:0] sa, input int len, input int exp_off,
                         input bit glitch);
    done_t d;
    logic [7:0] sum = 8'h00;
    for (int i = 0; i < len; i++) begin
      wq.push_back('{addr: sa + AW'(i), data: lb[i]});
      sum = sum + lb[i];
    end
    d.cyc  = (exp_off >= 0) ? cyc + 1 + exp_off : -1;
    d.csum = sum;
    dq.push_back(d);

    start      = 1'b1;
    start_addr = sa;
    length     = AW'(len);
    @(negedge clk);
    start      = 1'b0;
    start_addr = AW'($urandom);
    length     = AW'($urandom);

    if (len == 0) begin
      check("len0_busy", 32'(busy), 32'd0);
      check("len0_ready", 32'(bus.nib_ready), 32'd0);
      @(negedge clk);
      check("len0_busy_after", 32'(busy), 32'd0);
      return;
    end

    check("ready_after_start", 32'(bus.nib_ready), 32'd1);
    for (int i = 0; i < len; i++) begin
      repeat (gh[i]) @(negedge clk);
      send_nib(lb[i][7:4]);
      for (int g = 0; g < gl[i]; g++) begin
        check("wait_lo_ready", 32'(bus.nib_ready), 32'd1);
        check("wait_lo_busy", 32'(busy), 32'd1);
        if (glitch && g == 0) begin
          start      = 1'b1;
          start_addr = sa ^ AW'(12'h800);
          length     = AW'(7);
        end
        @(negedge clk);
        start = 1'b0;
      end
      send_nib(lb[i][3:0]);
    end
    // Now in the last WRITE cycle; DONE follows. A start during DONE must be ignored.
    @(negedge clk);
    start      = 1'b1;
    start_addr = AW'(12'h555);
    length     = AW'(2);
    @(negedge clk);
    start = 1'b0;
    check("start_in_done_ignored_busy", 32'(busy), 32'd0);
    check("start_in_done_ignored_ready", 32'(bus.nib_ready), 32'd0);
    @(negedge clk);
  endtask

  task automatic clear_gaps();
    for (int i = 0; i < 16; i++) begin
      gh[i] = 0;
      gl[i] = 0;
    end
  endtask

  task automatic set_abc();
    lb[0] = 8'h1A;
    lb[1] = 8'h2B;
    lb[2] = 8'h3C;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset         = 1'b1;
    start         = 1'b0;
    start_addr    = '0;
    length        = '0;
    bus.nib_valid = 1'b0;
    bus.nib       = 4'h0;
    clear_gaps();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset  = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // Basic 3-byte load, valid held high: done in the tenth cycle after the start edge.
    set_abc();
    do_load(AW'(12'h002), 3, 9, 1'b0);

    // Valid dropped for 4 cycles between nibbles of byte 2: done 4 cycles later.
    gl[1] = 4;
    do_load(AW'(12'h002), 3, 13, 1'b0);
    clear_gaps();

    // Address wrap; checksum 0xFF + 0x01 wraps to 0x00.
    lb[0] = 8'hFF;
    lb[1] = 8'h01;
    do_load(AW'(12'hFFF), 2, 6, 1'b0);

    // Zero length: done in the cycle right after the start edge.
    do_load(AW'(12'h123), 0, 0, 1'b0);

    // Start pulsed mid-load with a different address must be ignored.
    set_abc();
    gl[1] = 2;
    do_load(AW'(12'h040), 3, 11, 1'b1);
    clear_gaps();

    // Reset after the high nibble of byte 2: only byte 1 written, no done.
    start      = 1'b1;
    start_addr = AW'(12'h100);
    length     = AW'(3);
    wq.push_back('{addr: AW'(12'h100), data: 8'h1A});
    @(negedge clk);
    start = 1'b0;
    send_nib(4'h1);
    send_nib(4'hA);
    send_nib(4'h2);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("midload_reset");
    check("midload_pending_writes", 32'(wq.size()), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("midload_no_done", 32'(done), 32'd0);

    // Normal operation after the mid-load reset.
    do_load(AW'(12'h002), 3, 9, 1'b0);

    // Randomised loads, biased toward the top of the address space.
    for (int r = 0; r < 8; r++) begin
      int len = $urandom_range(1, 6);
      logic [AW-1:0] sa;
      sa = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(4090, 4095)) : AW'($urandom);
      for (int i = 0; i < len; i++) begin
        lb[i] = 8'($urandom);
        gh[i] = $urandom_range(0, 2);
        gl[i] = $urandom_range(0, 2);
      end
      do_load(sa, len, -1, 1'b0);
      clear_gaps();
    end

    repeat (4) @(negedge clk);
    check("final_write_queue_empty", 32'(wq.size()), 32'd0);
    check("final_done_queue_empty", 32'(dq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Writer side of the program memory path: accepts a stream of 4-bit nibbles over a valid/ready handshake and packs each pair into one program byte. The high nibble is the instruction field and the low nibble is the operand field. It then writes the byte into the 4K x 8 program memory at an auto-incrementing 12-bit address. It sits in front of the program memory write port, mirroring the fetch path, which reads bytes back and splits them into `inst`/`oprnd`.

## Interface
Parameters:
- `ADDR_W`, 12, program memory address width (the address space is 2^ADDR_W bytes).

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a load; sampled only in IDLE.
- `start_addr`  in  ADDR_W  first address to write.
- `length`  in  ADDR_W  number of bytes to write; 0 means no writes.
- `nib_valid`  in  1  `nib` holds a valid nibble.
- `nib`  in  4  nibble data: high (instruction) first, then low (operand).
- `nib_ready`  out  1  loader can accept a nibble this cycle.
- `mem_we`  out  1  program memory write enable.
- `mem_addr`  out  ADDR_W  write address.
- `mem_data`  out  8  write data, formed as {high nibble, low nibble}.
- `busy`  out  1  a load is in progress.
- `done`  out  1  one-cycle pulse when a load completes.
- `checksum`  out  8  only present with `LOADER_CHECKSUM_EN`; see Configuration.

## Operation
States:
- IDLE
  - `start`=1 latches `start_addr` into the address counter and `length` into the remaining-byte counter.
  - Goes to DONE if `length`==0, otherwise to HI.
  - `start`=0 stays in IDLE.
- HI
  - `nib_ready`=1.
  - On the edge where `nib_valid`=1, `nib` is stored as the high nibble and the state goes to LO.
- LO
  - `nib_ready`=1.
  - On the edge where `nib_valid`=1, `nib` is stored as the low nibble and the state goes to WRITE.
- WRITE
  - `nib_ready`=0, `mem_we`=1, `mem_addr`=current address, `mem_data`={hi,lo}.
  - At the edge, the address increments by 1 modulo 2^ADDR_W and remaining decrements by 1.
  - Next state is DONE if remaining was 1, otherwise HI.
- DONE
  - `done`=1 for exactly one cycle, then IDLE.

Rules:
- A nibble transfers only on an edge where `nib_valid` and `nib_ready` are both 1.
- `nib` is don't-care when `nib_valid`=0.
- `busy`=1 in HI, LO and WRITE; `busy`=0 in IDLE and DONE.
- `start` is ignored outside IDLE, including in DONE.
- `mem_addr` and `mem_data` hold their last driven values when `mem_we`=0. Only `mem_we` qualifies them.
- Address wrap: after a write to 2^ADDR_W−1, the next write goes to 0 with no error.

## Timing
- Reset values:
  - State IDLE.
  - `nib_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_data`=0, `busy`=0, `done`=0, `checksum`=0.
  - Internal counters cleared.
- Reset mid-load returns to IDLE on the next edge:
  - A partially received byte is discarded.
  - No write is issued.
  - `done` is not pulsed.
- Latency:
  - `start` edge → `nib_ready`=1 in the next cycle.
  - Low-nibble acceptance edge → `mem_we`=1 in the next cycle.
  - Final write cycle → `done`=1 in the following cycle.
- Throughput: at most 1 byte per 3 cycles (HI, LO, WRITE); `nib_ready` drops in the WRITE cycle.
- All outputs are registered or decoded from state only; there is no combinational path from `nib_valid` to `nib_ready`.

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - `checksum` port exists: an 8-bit modulo-256 sum of every `mem_data` value written in the current load.
  - Cleared to 0 when `start` is accepted in IDLE.
  - Updated at the edge ending each WRITE cycle.
  - Stable and valid while `done`=1, and held until the next accepted `start` or reset.
- Not defined: the `checksum` port and its adder are absent; all other behaviour is identical.

## Test plan
- Reset then `start` with `start_addr`=0x002, `length`=3; nibbles 1,A,2,B,3,C with `nib_valid` held high:
  - Writes 0x1A@0x002, 0x2B@0x003, 0x3C@0x004.
  - Single `done` pulse 10 cycles after the `start` edge.
  - `checksum`=0x81 (macro on).
- Same load with `nib_valid` deasserted for 4 cycles between the high and low nibble of byte 2:
  - The loader waits in LO with `nib_ready`=1.
  - Identical writes; `done` is delayed by 4 cycles.
- `start_addr`=0xFFF, `length`=2, nibbles F,F,0,1:
  - Writes 0xFF@0xFFF, then 0x01@0x000.
  - `checksum`=0x00.
- `length`=0:
  - `done` pulses in the cycle after `start`.
  - No `mem_we`; `busy` never asserts.
- Assert `reset` after the high nibble of byte 2 of a 3-byte load:
  - Only byte 1 is written.
  - Next cycle: all outputs at reset values, no `done`.
  - A new `start` then works normally.
- Pulse `start` with a different `start_addr` while busy:
  - Ignored; the original address sequence and length complete unchanged.
